counter: RTL and testbench
==========================

Name: counter

Overview:
- Free-running binary up-counter with an asynchronous clear. Default width is 4 bits.
- Built as a ripple chain of toggle stages. Stage 0 toggles on the falling edge of CLOCK; each later stage toggles on the falling edge of the previous stage's output.
- General-purpose event/cycle counter. Also the reference toggle-stage ripple structure for the team's counter family.

Parameters:
- WIDTH, 4, number of count bits / toggle stages. Legal range 1..32.

Ports (positional order is Q, CLOCK, CLEAR):
- CLOCK  input  1  count clock. Count advances on the falling edge.
- CLEAR  input  1  asynchronous, active-low reset. 0 forces the count to zero immediately.
- Q  output  WIDTH  current count, unsigned binary, Q[0] = LSB.

Behaviour:
- Reset: while CLEAR=0, Q = 0 on all bits, independent of CLOCK.
  - Assertion takes effect at once, with no clock edge required, including mid-count or during a ripple.
  - Every stage is cleared simultaneously.
- Counting: while CLEAR=1, each falling edge of CLOCK increments Q by 1 modulo 2^WIDTH.
  - Rising edges of CLOCK never change Q.
- Structure:
  - Bit i (i>0) toggles on the 1->0 transition of bit i-1.
  - Bit 0 toggles on the 1->0 transition of CLOCK.
  - Each stage is a toggle flip-flop: a D storage element with feedback of its inverted output, plus asynchronous active-low clear.
  - Stages are implemented as a reusable toggle-stage submodule instantiated WIDTH times via a generate loop.
- Latency and timing:
  - No modelled gate delays; Q settles in the same simulation time step as the causing CLOCK edge.
  - Intermediate ripple values may be visible within that time step only. Q must be stable before the next CLOCK edge.
- Wrap-around: from all-ones (15 for WIDTH=4), the next falling edge gives 0. The carry ripples through all stages; there is no terminal-count output.
- Clear release:
  - After CLEAR 0->1, the first increment occurs on the next falling edge of CLOCK.
  - If CLEAR rises in the same time step as a CLOCK falling edge, that edge is not counted; Q stays 0 until the following falling edge.
- Simultaneous clear and edge: if CLEAR=0 at a CLOCK falling edge, Q stays 0. Clear dominates.
- Power-up: Q is undefined (X) until the first CLEAR assertion. The system must assert CLEAR before counting is relied upon.
- Combinational paths: no combinational path from CLEAR to Q other than the asynchronous clear of the stage elements.
- Unsupported conditions: no enable, load or down-count. CLOCK glitches shorter than a stage's response are not supported.

Test Plan:
1. Clear hold: CLOCK period 20 (falling edges at t=20,40,...), CLEAR=0 from t=0 to t=34 -> Q=0000 throughout, including across the edge at t=20.
2. Count up: CLEAR=1 from t=34 -> Q=0001 at t=40, 0010 at t=60, ... Q=N after N falling edges. No Q change on rising edges (t=30, 50, ...).
3. Wrap: continue counting to Q=1111 -> next falling edge gives Q=0000, then 0001. Q must never show a stale or skipped value between edges.
4. Asynchronous clear mid-count: with Q nonzero, drive CLEAR=0 between clock edges (e.g. t=234) -> Q=0000 in the same time step. Q holds 0 for 50 time units regardless of edges.
5. Release and resume: CLEAR=1 at t=284 -> Q=0001 at the falling edge at t=300, then counting continues normally.
6. Edge coincidence: drive CLEAR 0->1 exactly at a CLOCK falling edge -> Q stays 0000 at that edge and becomes 0001 on the next falling edge.

Source files
------------

// File: rtl/counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : counter (with toggle stage counter_tstage)
//  Brief    : Ripple up-counter of WIDTH falling-edge toggle stages with an
//             asynchronous active-low clear. WIDTH legal range 1..32.
//  Revision : 1.0 - initial release
// ============================================================================

module counter_tstage (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_q
);

  logic r_q;

  // Toggle flop: D is the inverted stored value whenever the stage is enabled.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_en ? ~r_q : r_q;
    end
  end

  assign o_q = r_q;

endmodule

module counter #(
  parameter int WIDTH = 4
) (
  output logic [WIDTH-1:0] Q,
  input  logic             CLOCK,
  input  logic             CLEAR
);

  logic             r_armed;
  logic [WIDTH-1:0] w_tclk;
  logic [WIDTH-1:0] w_q;

  // Release qualifier for stage 0: only opens while CLOCK is high, so a CLEAR
  // release landing on a falling edge cannot let that same edge count.
  always_latch begin
    if (!CLEAR) begin
      r_armed <= 1'b0;
    end else if (CLOCK) begin
      r_armed <= 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      if (i == 0) begin : g_lsb
        assign w_tclk[i] = CLOCK;
      end else begin : g_ripple
        assign w_tclk[i] = w_q[i-1];
      end

      counter_tstage u_stage (
        .clk   (w_tclk[i]),
        .rst_n (CLEAR),
        .i_en  ((i == 0) ? r_armed : 1'b1),
        .o_q   (w_q[i])
      );
    end
  endgenerate

  assign Q = w_q;

endmodule

`default_nettype wire

// File: tb/tb_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_counter
//  Brief    : Vector table, corner sequences and random run for counter.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_counter;

  localparam int WIDTH = 4;
  localparam int MODV  = 1 << WIDTH;

  logic [WIDTH-1:0] Q;
  logic             CLOCK;
  logic             CLEAR;

  int checks = 0;
  int errors = 0;

  counter #(.WIDTH(WIDTH)) dut (
    .Q     (Q),
    .CLOCK (CLOCK),
    .CLEAR (CLEAR)
  );

  // Rising edges at 10, 30, 50 ...; falling edges at 20, 40, 60 ...
  initial begin
    CLOCK = 1'b0;
    forever #10 CLOCK = ~CLOCK;
  end

  typedef struct {
    logic             clear;
    int               dt;
    logic [WIDTH-1:0] exp;
    string            name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic c, input int dt, input int e, input string n);
    vec_t v;
    v.clear = c;
    v.dt    = dt;
    v.exp   = e[WIDTH-1:0];
    v.name  = n;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] exp);
    checks++;
    if (Q !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: Q=%0d expected %0d", name, $time, Q, exp);
    end
  endtask

  int model;
  int n;

  initial begin
    CLEAR = 1'b0;

    // Timeline: clear hold, count, async clear at 234, release at 284, wrap.
    add(0, 5,  0, "reset");
    add(0, 20, 0, "clear_hold_edge20");
    add(0, 9,  0, "clear_hold_t34");
    add(1, 1,  0, "release_no_change");
    add(1, 6,  1, "count_t40");
    add(1, 10, 1, "rising_no_change");
    add(1, 10, 2, "count_t60");
    for (int k = 3; k <= 10; k++) add(1, 20, k, "count_up");
    add(1, 13, 10, "pre_clear_t234");
    add(0, 1,  0, "async_clear");
    add(0, 6,  0, "clear_hold_240");
    add(0, 20, 0, "clear_hold_260");
    add(0, 20, 0, "clear_hold_280");
    add(0, 3,  0, "clear_hold_284");
    add(1, 1,  0, "release_284");
    add(1, 16, 1, "resume_t300");
    add(1, 20, 2, "resume_t320");
    for (int k = 3; k <= 15; k++) add(1, 20, k, "count_to_max");
    add(1, 20, 0, "wrap_to_zero");
    add(1, 20, 1, "wrap_then_one");
    add(1, 10, 1, "rising_after_wrap");

    for (int i = 0; i < vecs.size(); i++) begin
      CLEAR = vecs[i].clear;
      #(vecs[i].dt);
      check(vecs[i].name, vecs[i].exp);
    end

    // t=631: release coinciding exactly with the falling edge at t=660.
    CLEAR = 1'b0;
    #4;  check("coin_clear", 0);
    #25; CLEAR = 1'b1;
    #1;  check("coin_edge_not_counted", 0);
    #20; check("coin_next_edge", 1);
    #20; check("coin_second_edge", 2);

    // Clear asserted exactly at the 7->8 edge, where the carry ripples fully.
    #100; check("pre_ripple_clear", 7);
    #19; CLEAR = 1'b0;
    #1;  check("clear_during_ripple", 0);
    #20; check("clear_dominates_edge", 0);

    // Randomized run against a count-of-edges model.
    #5; CLEAR = 1'b1;
    model = 0;
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 4) != 0) begin
        n = $urandom_range(1, 24);
        for (int e = 0; e < n; e++) begin
          @(negedge CLOCK);
          #1;
          model = (model + 1) % MODV;
          check("rand_count", model[WIDTH-1:0]);
        end
      end else begin
        #($urandom_range(2, 8));
        CLEAR = 1'b0;
        #1;
        model = 0;
        check("rand_clear", 0);
        n = $urandom_range(0, 3);
        for (int e = 0; e < n; e++) begin
          @(negedge CLOCK);
          #1;
          check("rand_hold", 0);
        end
        #($urandom_range(2, 8));
        CLEAR = 1'b1;
        #1;
        check("rand_release", 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
